// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: OTTER fetch stage - owns PC, single-outstanding imem handshake,
// one-entry instruction buffer, squashes wrong-path fetches on redirect.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pc_source,
  input  logic [31:0] jalr_tgt,
  input  logic [31:0] branch_tgt,
  input  logic [31:0] jal_tgt,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        if_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);
  typedef enum logic [1:0] {BOOT, FETCH, FULL, DRAIN} state_t;
  state_t      state;
  logic [31:0] pc, redir_pc, tgt_raw, tgt;
  logic        redir;
  always_comb begin
    redir   = (pc_source >= 3'd1) && (pc_source <= 3'd5);
    tgt_raw = pc_source == 3'd1 ? jalr_tgt :
              pc_source == 3'd2 ? branch_tgt :
              pc_source == 3'd3 ? jal_tgt :
              pc_source == 3'd4 ? mtvec : mepc;
    tgt     = {tgt_raw[31:2], 2'b00};
  end
  // In FULL the next request is issued combinationally as decode drains the buffer
  assign imem_req  = (state == FETCH) || (state == DRAIN) ||
                     ((state == FULL) && if_ready && !redir);
  assign imem_addr = pc;
  assign if_valid  = state == FULL;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_VEC;
      redir_pc <= 32'h0;
      if_instr <= 32'h0000_0013;
      if_pc    <= 32'h0;
    end else begin
      case (state)
        BOOT: begin
          if (redir) pc <= tgt;
          state <= FETCH;
        end
        FETCH: begin
          if (imem_ack && !redir) begin
            if_instr <= imem_rdata;
            if_pc    <= pc;
            pc       <= pc + 32'd4;
            state    <= FULL;
          end else if (imem_ack) begin
            pc <= tgt;
          end else if (redir) begin
            redir_pc <= tgt;
            state    <= DRAIN;
          end
        end
        FULL: begin
          if (redir) begin
            pc    <= tgt;
            state <= FETCH;
          end else if (if_ready && imem_ack) begin
            if_instr <= imem_rdata;
            if_pc    <= pc;
            pc       <= pc + 32'd4;
          end else if (if_ready) begin
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            pc    <= redir ? tgt : redir_pc;
            state <= FETCH;
          end else if (redir) begin
            redir_pc <= tgt;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed test-plan steps plus random traffic, checked against
// a transaction-level model (outstanding request, deferred redirect, buffer).
module tb_pc_fetch_unit;
  logic        clk = 0, rst_n = 0;
  logic [2:0]  pc_source = 0;
  logic [31:0] jalr_tgt = 0, branch_tgt = 0, jal_tgt = 0, mtvec = 0, mepc = 0;
  logic        imem_ack = 0, if_ready = 0;
  logic [31:0] imem_rdata = 0;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc;
  int compared = 0, mismatched = 0;

  pc_fetch_unit #(.RESET_VEC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .pc_source(pc_source),
    .jalr_tgt(jalr_tgt), .branch_tgt(branch_tgt), .jal_tgt(jal_tgt),
    .mtvec(mtvec), .mepc(mepc), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_ready(if_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  // Model: boot cycle flag, buffered instruction, redirect deferred behind an unacked request
  logic        m_boot, m_bv, m_def, m_req;
  logic [31:0] m_pc, m_dtgt, m_instr, m_bpc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_redir(input logic [2:0] s);
    return s inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  endfunction

  function automatic logic [31:0] target(input logic [2:0] s);
    logic [31:0] t [8];
    t = '{0, jalr_tgt, branch_tgt, jal_tgt, mtvec, mepc, 0, 0};
    return t[s] & ~32'd3;
  endfunction

  task automatic model_reset();
    m_boot = 1; m_bv = 0; m_def = 0; m_pc = 32'h100; m_dtgt = 0;
    m_instr = 32'h13; m_bpc = 0;
  endtask

  task automatic compare_all();
    m_req = !m_boot && (!m_bv || (if_ready && !is_redir(pc_source)));
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_bv});
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", if_pc, m_bpc);
  endtask

  task automatic drive(input logic [2:0] src, input logic ack, input logic rdy);
    pc_source = src; imem_ack = ack; if_ready = rdy; imem_rdata = $urandom;
    #1 compare_all();
  endtask

  task automatic tick();
    logic r;
    logic [31:0] t;
    r = is_redir(pc_source);
    t = target(pc_source);
    @(posedge clk);
    if (m_boot) begin
      m_boot = 0;
      if (r) m_pc = t;
    end else if (r) begin
      m_bv = 0;
      if (m_req && !imem_ack) begin m_def = 1; m_dtgt = t; end
      else begin m_pc = t; m_def = 0; end
    end else begin
      if (m_bv && if_ready) m_bv = 0;
      if (m_req && imem_ack) begin
        if (m_def) begin m_pc = m_dtgt; m_def = 0; end
        else begin m_bv = 1; m_instr = imem_rdata; m_bpc = m_pc; m_pc = m_pc + 32'd4; end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0; pc_source = 0; imem_ack = 0; if_ready = 0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [31:0] p, si, sp;
    @(negedge clk);
    do_reset();
    // zero-wait stream from RESET_VEC
    drive(0, 1, 1); chk("boot_req", {31'd0, imem_req}, 0); tick();
    drive(0, 1, 1); chk("seq_a0", imem_addr, 32'h100); chk("first_req", {31'd0, imem_req}, 1); tick();
    drive(0, 1, 1); chk("seq_a1", imem_addr, 32'h104); chk("seq_pc0", if_pc, 32'h100);
    chk("valid_c3", {31'd0, if_valid}, 1); tick();
    drive(0, 1, 1); chk("seq_a2", imem_addr, 32'h108); chk("seq_pc1", if_pc, 32'h104); tick();
    // branch taken in FULL, low bits forced to zero
    branch_tgt = 32'h203;
    drive(2, 1, 1); chk("br_req", {31'd0, imem_req}, 0); tick();
    drive(0, 1, 1); chk("br_valid", {31'd0, if_valid}, 0); chk("br_addr", imem_addr, 32'h200); tick();
    // JAL while an ACK is pending: old address held, stale data dropped
    drive(0, 0, 1); tick();
    p = m_pc; jal_tgt = 32'h40;
    drive(3, 0, 1); chk("jal_hold0", imem_addr, p); tick();
    drive(0, 0, 1); chk("jal_hold1", imem_addr, p); tick();
    drive(0, 0, 1); tick();
    drive(0, 1, 1); chk("jal_hold2", imem_addr, p); tick();
    drive(0, 1, 1); chk("jal_addr", imem_addr, 32'h40); chk("jal_valid", {31'd0, if_valid}, 0); tick();
    // two redirects while draining: newest wins
    drive(0, 0, 1); tick();
    jalr_tgt = 32'h80; drive(1, 0, 1); tick();
    mtvec = 32'hC0; drive(4, 0, 1); tick();
    drive(0, 1, 1); tick();
    drive(0, 1, 1); chk("drain_new", imem_addr, 32'hC0); tick();
    // decode stall in FULL
    si = if_instr; sp = if_pc; p = imem_addr;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0); chk("stall_req", {31'd0, imem_req}, 0);
      chk("stall_instr", if_instr, si); chk("stall_addr", imem_addr, p); tick();
    end
    drive(0, 1, 1); chk("unstall_req", {31'd0, imem_req}, 1); chk("unstall_pc", if_pc, sp); tick();
    // PC wrap at the top of the address space
    jal_tgt = 32'hFFFF_FFFE;
    drive(3, 0, 1); tick();
    drive(0, 1, 1); chk("wrap_top", imem_addr, 32'hFFFF_FFFC); tick();
    drive(0, 0, 1); chk("wrap_zero", imem_addr, 32'h0); tick();
    // reset with a request outstanding, stale ACK after release
    drive(0, 0, 1); tick();
    do_reset();
    drive(0, 1, 1); chk("rst_valid", {31'd0, if_valid}, 0); tick();
    drive(0, 0, 1); chk("rst_addr", imem_addr, 32'h100); chk("rst_req", {31'd0, imem_req}, 1); tick();
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      jalr_tgt = $urandom; branch_tgt = $urandom; jal_tgt = $urandom;
      mtvec = $urandom; mepc = $urandom;
      if ($urandom_range(0, 199) == 0) do_reset();
      drive(($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0,
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage of the OTTER 5-stage pipeline, directly downstream of the branch condition generator. Consumes its 3-bit `pcSource` code, registered in EX, together with the candidate targets. Owns the program counter, runs a single-outstanding request/acknowledge handshake with instruction memory, and holds one fetched instruction for decode. Squashes wrong-path fetches on any redirect.

## Interface
Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded at reset.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- PC_SOURCE  in  3  redirect code from the branch condition generator.
  - 0 = sequential.
  - 1 = JALR.
  - 2 = branch taken.
  - 3 = JAL.
  - 4 = interrupt (MTVEC).
  - 5 = MRET (MEPC).
  - 6 and 7 = sequential.
- JALR_TGT, BRANCH_TGT, JAL_TGT, MTVEC, MEPC  in  32 each  candidate targets.
- IMEM_ACK  in  1  memory accepted the request; IMEM_RDATA is valid this cycle.
- IMEM_RDATA  in  32  instruction word.
- IF_READY  in  1  decode accepts the held instruction this cycle.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  32  fetch address; always equals PC.
- IF_VALID  out  1  IF_INSTR/IF_PC hold a valid instruction.
- IF_INSTR  out  32  held instruction.
- IF_PC  out  32  address of the held instruction.

## Operation
- A redirect occurs when PC_SOURCE is 1..5. The target is chosen from PC_SOURCE, and its bits [1:0] are forced to 00.
- Redirect has priority over every other event in every state.
- States: BOOT, FETCH, FULL, DRAIN. Reset state is BOOT.
- Registers: PC, REDIR_PC, IF_INSTR, IF_PC.
- BOOT:
  - IMEM_REQ=0, IF_VALID=0.
  - Next state is FETCH.
  - A redirect in BOOT sets PC to the target.
- FETCH:
  - IMEM_REQ=1, IF_VALID=0.
  - ACK without redirect: IF_INSTR<=IMEM_RDATA, IF_PC<=PC, PC<=PC+4, next state FULL.
  - ACK with redirect: data dropped, PC<=target, stay in FETCH.
  - Redirect without ACK: REDIR_PC<=target, next state DRAIN. The address stays stable until the ACK arrives.
- FULL:
  - IF_VALID=1.
  - IMEM_REQ = IF_READY && !redirect. This is a combinational path from IF_READY and PC_SOURCE; it is intended.
  - Redirect: buffer invalidated, PC<=target, next state FETCH.
  - IF_READY with ACK: load the new instruction, PC<=PC+4, stay in FULL.
  - IF_READY without ACK: next state FETCH. The request continues to be held there.
  - !IF_READY: hold the buffer and PC.
- DRAIN:
  - IMEM_REQ=1, IF_VALID=0. IMEM_ADDR holds the old PC.
  - A redirect without ACK overwrites REDIR_PC; the newest redirect wins.
  - ACK without redirect: data dropped, PC<=REDIR_PC, next state FETCH.
  - ACK with redirect: data dropped, PC<=new target, next state FETCH.
- Once IMEM_REQ rises, it and IMEM_ADDR stay stable until the ACK, except on the FULL-state combinational issue.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - State = BOOT.
  - PC = RESET_VEC, REDIR_PC = 0.
  - IMEM_REQ=0, IMEM_ADDR=RESET_VEC.
  - IF_VALID=0, IF_INSTR=32'h0000_0013 (NOP), IF_PC=0.
- Reset asserted mid-request: all state clears immediately. The in-flight ACK after release is ignored, because BOOT does not sample IMEM_ACK.
- First request is issued in the 2nd cycle after RST_N rises.
- Fetch latency: request cycle to IF_VALID = ACK latency + 1 cycle.
- With zero-wait memory and IF_READY held high, throughput is 1 instruction/cycle.
- Redirect penalty:
  - Redirect in FULL: the target request is issued the next cycle.
  - Redirect in FETCH with ACK pending: the target request is issued the cycle after the stale ACK.
- IF_VALID never goes high for a squashed instruction.

## Test plan
- Reset with RESET_VEC=32'h100, zero-wait memory, IF_READY=1 -> IMEM_ADDR sequence 0x100, 0x104, 0x108; IF_VALID from cycle 3; IF_PC trails IMEM_ADDR by one cycle.
- PC_SOURCE=2 with BRANCH_TGT=0x203 pulsed in FULL -> IF_VALID=0 next cycle; next IMEM_ADDR=0x200; old buffer never consumed.
- ACK delayed 3 cycles and PC_SOURCE=3 (JAL_TGT=0x40) in the first wait cycle -> IMEM_ADDR stays at the old PC until the ACK; data dropped; next request at 0x40.
- Two redirects in DRAIN (JALR_TGT=0x80, then MTVEC=0xC0) before the ACK -> next request is 0xC0.
- IF_READY=0 for 5 cycles in FULL -> IMEM_REQ=0, buffer and PC unchanged; IF_READY=1 -> request issued the same cycle.
- RST_N low during a pending request, then ACK arrives after release -> IF_VALID stays 0; first request at RESET_VEC.
